// File: rtl/down_counter_4bit.sv
// Loadable down-counter/timer with one-shot or auto-reload terminal-count behaviour.
// Latency: state updates on the falling edge of clk; first decrement on the edge after start.
// Backpressure: none; t gates decrementing, and load > abort > start > t each edge.
module down_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             abort,
    input  logic             t,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("down_counter_4bit: WIDTH must be at least 2");
        end
    endgenerate

    logic             state;
    logic [WIDTH-1:0] preset;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            q      <= '0;
            preset <= '0;
            tc     <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                q      <= load_val;
                preset <= load_val;
                state  <= ST_IDLE;
            end else if (state == ST_RUN) begin
                if (abort) begin
                    state <= ST_IDLE;
                end else if (t) begin
                    if (q == WIDTH'(1)) begin
                        tc <= 1'b1;
                        // auto_reload only matters here, so changing it mid-run is harmless
                        if (auto_reload && (preset != '0)) begin
                            q <= preset;
                        end else begin
                            q     <= '0;
                            state <= ST_IDLE;
                        end
                    end else if (q != '0) begin
                        q <= q - WIDTH'(1);
                    end
                end
            end else if (start && (q != '0)) begin
                state <= ST_RUN;
            end
        end
    end

    assign busy = state;

endmodule
